// File: rtl/scalar_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : scalar_mult_ctrl
//  Description : Left-to-right double-and-add sequencer for Ed25519
//                variable-base scalar multiplication Q = k*P. Scans the
//                scalar from its top set bit downward and issues LOAD / DBL /
//                ADD / CLEAR commands to the shared point unit over a
//                start/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module scalar_mult_ctrl #(
    parameter int N          = 255,
    parameter int CONST_TIME = 0,
    localparam int IW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  k,
    input  logic          abort,
    output logic          op_start,
    output logic [1:0]    op_code,
    output logic          op_discard,
    input  logic          op_done,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] bit_idx,
    output logic [9:0]    op_count
);

    localparam logic [1:0] c_op_load  = 2'b00;
    localparam logic [1:0] c_op_dbl   = 2'b01;
    localparam logic [1:0] c_op_add   = 2'b10;
    localparam logic [1:0] c_op_clear = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_NEXT  = 3'd4,
        S_FIN   = 3'd5,
        S_DRAIN = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_ks;
    logic [N-1:0]  w_ks_nxt;
    logic [IW-1:0] r_bit_idx;
    logic [IW-1:0] w_bit_idx_nxt;
    logic [1:0]    r_cmd;
    logic [1:0]    w_cmd_nxt;
    logic          r_discard;
    logic          w_discard_nxt;
    logic [9:0]    r_op_count;
    logic [9:0]    w_count_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_abort;
    logic          w_abort_nxt;
    logic          w_bit_done;
    logic [IW-1:0] w_msb;

    // Priority encoder: index of the highest set bit of the latched scalar
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < N; i++) begin
            if (r_ks[i]) begin
                w_msb = IW'(i);
            end
        end
    end

    // State and datapath registers, cleared asynchronously with the point unit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ks       <= '0;
            r_bit_idx  <= '0;
            r_cmd      <= c_op_load;
            r_discard  <= 1'b0;
            r_op_count <= '0;
            r_busy     <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ks       <= w_ks_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_cmd      <= w_cmd_nxt;
            r_discard  <= w_discard_nxt;
            r_op_count <= w_count_nxt;
            r_busy     <= w_busy_nxt;
            r_abort    <= w_abort_nxt;
        end
    end

    // Next-state sequencing and output decode; outputs depend only on
    // registered state, so op_done never reaches op_start combinationally
    always_comb begin
        w_state_nxt   = r_state;
        w_ks_nxt      = r_ks;
        w_bit_idx_nxt = r_bit_idx;
        w_cmd_nxt     = r_cmd;
        w_discard_nxt = r_discard;
        w_count_nxt   = r_op_count;
        w_busy_nxt    = r_busy;
        w_abort_nxt   = r_abort;
        w_bit_done    = 1'b0;

        op_start   = (r_state == S_ISSUE);
        op_code    = r_cmd;
        op_discard = (r_state == S_ISSUE) && r_discard;
        done       = (r_state == S_FIN);
        busy       = r_busy;
        bit_idx    = r_bit_idx;
        op_count   = r_op_count;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ks_nxt    = k;
                    w_count_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_abort_nxt = 1'b0;
                    w_state_nxt = S_SCAN;
                end
            end

            S_SCAN: begin
                // A zero scalar yields the identity; otherwise start from P
                if (r_ks == '0) begin
                    w_cmd_nxt = c_op_clear;
                end else begin
                    w_cmd_nxt     = c_op_load;
                    w_bit_idx_nxt = w_msb;
                end
                w_discard_nxt = 1'b0;
                if (abort) begin
                    w_abort_nxt = 1'b1;
                end
                w_state_nxt = S_ISSUE;
            end

            S_ISSUE: begin
                // The command goes out even when aborting, so it must be drained
                w_count_nxt = r_op_count + 10'd1;
                if (abort || r_abort) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (abort) begin
                    if (op_done) begin
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (op_done) begin
                    w_state_nxt = S_NEXT;
                end
            end

            S_NEXT: begin
                if (abort) begin
                    // Last command already completed, nothing outstanding
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    case (r_cmd)
                        c_op_clear: begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_FIN;
                        end
                        c_op_dbl: begin
                            if (r_ks[r_bit_idx]) begin
                                w_cmd_nxt     = c_op_add;
                                w_discard_nxt = 1'b0;
                                w_state_nxt   = S_ISSUE;
                            end else if (CONST_TIME != 0) begin
                                // Dummy add keeps the command stream bit-independent
                                w_cmd_nxt     = c_op_add;
                                w_discard_nxt = 1'b1;
                                w_state_nxt   = S_ISSUE;
                            end else begin
                                w_bit_done = 1'b1;
                            end
                        end
                        default: begin
                            w_bit_done = 1'b1;
                        end
                    endcase

                    if (w_bit_done) begin
                        if (r_bit_idx == '0) begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_FIN;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx - IW'(1);
                            w_cmd_nxt     = c_op_dbl;
                            w_discard_nxt = 1'b0;
                            w_state_nxt   = S_ISSUE;
                        end
                    end
                end
            end

            S_FIN: begin
                w_state_nxt = S_IDLE;
            end

            S_DRAIN: begin
                if (op_done) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_scalar_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scalar_mult_ctrl
//  Description : Self-checking bench for scalar_mult_ctrl. Two instances
//                (CONST_TIME = 0 and 1) each driven by a simple point-unit
//                responder; expected command streams come from a reference
//                double-and-add model through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scalar_mult_ctrl;

    localparam int N     = 255;
    localparam int IW    = $clog2(N);
    localparam int LIMIT = 6000;

    typedef struct {
        logic [1:0] code;
        logic       disc;
        int         idx;
    } exp_t;

    typedef struct {
        int         sel;
        logic [N-1:0] k;
        int         cnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_s      [2];
    logic [N-1:0]  k_s          [2];
    logic          abort_s      [2];
    logic          op_start_s   [2];
    logic [1:0]    op_code_s    [2];
    logic          op_discard_s [2];
    logic          op_done_s    [2];
    logic          busy_s       [2];
    logic          done_s       [2];
    logic [IW-1:0] bit_idx_s    [2];
    logic [9:0]    op_count_s   [2];
    logic          man_done     [2];
    int            pu_delay;

    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];
    vec_t vecs[9];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic pu_done = 1'b0;
        int   cnt     = 0;

        assign op_done_s[g] = pu_done | man_done[g];

        scalar_mult_ctrl #(.N(N), .CONST_TIME(g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .start      (start_s[g]),
            .k          (k_s[g]),
            .abort      (abort_s[g]),
            .op_start   (op_start_s[g]),
            .op_code    (op_code_s[g]),
            .op_discard (op_discard_s[g]),
            .op_done    (op_done_s[g]),
            .busy       (busy_s[g]),
            .done       (done_s[g]),
            .bit_idx    (bit_idx_s[g]),
            .op_count   (op_count_s[g])
        );

        // Point unit: op_done pulses pu_delay cycles after each op_start
        always @(posedge clk) begin
            #1;
            if (!rst_n) begin
                cnt     = 0;
                pu_done = 1'b0;
            end else begin
                pu_done = 1'b0;
                if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) pu_done = 1'b1;
                end
                if (op_start_s[g]) cnt = pu_delay;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got event, expected none/other (t=%0t)", name, $time);
    endtask

    task automatic check_reset(input int sel);
        check("rst_op_start",   op_start_s[sel],   0);
        check("rst_op_code",    op_code_s[sel],    0);
        check("rst_op_discard", op_discard_s[sel], 0);
        check("rst_busy",       busy_s[sel],       0);
        check("rst_done",       done_s[sel],       0);
        check("rst_bit_idx",    bit_idx_s[sel],    0);
        check("rst_op_count",   op_count_s[sel],   0);
    endtask

    // Reference double-and-add: command stream for scalar kv
    task automatic push_expected(input bit ct, input logic [N-1:0] kv);
        int m;
        m = -1;
        for (int i = 0; i < N; i++) if (kv[i]) m = i;
        exp_q.delete();
        if (m < 0) begin
            exp_q.push_back('{2'b11, 1'b0, -1});
        end else begin
            exp_q.push_back('{2'b00, 1'b0, m});
            for (int i = m - 1; i >= 0; i--) begin
                exp_q.push_back('{2'b01, 1'b0, i});
                if (kv[i])   exp_q.push_back('{2'b10, 1'b0, i});
                else if (ct) exp_q.push_back('{2'b10, 1'b1, i});
            end
        end
    endtask

    // One multiply on instance sel; called and returns on a falling edge
    task automatic run_mult(input int sel, input logic [N-1:0] kv, input int exp_cnt, input int extra_at);
        exp_t e;
        int   cyc;
        int   last_done;
        bit   seen_first;
        bit   finished;
        push_expected(sel != 0, kv);
        check("busy_before_start", busy_s[sel], 0);
        start_s[sel] = 1'b1;
        k_s[sel]     = kv;
        @(negedge clk);
        start_s[sel] = 1'b0;
        cyc        = 1;
        last_done  = -100;
        seen_first = 1'b0;
        finished   = 1'b0;
        check("busy_after_start", busy_s[sel], 1);
        while (!finished && cyc < LIMIT) begin
            if (cyc == extra_at) begin
                start_s[sel] = 1'b1;
                k_s[sel]     = N'(1);
            end else begin
                start_s[sel] = 1'b0;
            end
            if (op_done_s[sel]) last_done = cyc;
            if (op_start_s[sel]) begin
                if (!seen_first) begin
                    check("first_op_latency", cyc, 2);
                    seen_first = 1'b1;
                end
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_op");
                end else begin
                    e = exp_q.pop_front();
                    check("op_code", op_code_s[sel], e.code);
                    check("op_discard", op_discard_s[sel], e.disc);
                    if (e.idx >= 0) check("bit_idx", bit_idx_s[sel], e.idx);
                end
            end
            if (done_s[sel]) begin
                check("op_count", op_count_s[sel], exp_cnt);
                check("busy_at_done", busy_s[sel], 0);
                check("done_latency", cyc - last_done, 2);
                check("ops_missing", exp_q.size(), 0);
                finished = 1'b1;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        start_s[sel] = 1'b0;
        if (!finished) begin
            fail_now("timeout_no_done");
        end else begin
            @(negedge clk);
            check("op_count_hold", op_count_s[sel], exp_cnt);
            check("done_single_pulse", done_s[sel], 0);
        end
    endtask

    initial begin
        int   n;
        int   cyc;
        logic [N-1:0] kv;
        n_cmp    = 0;
        n_fail   = 0;
        pu_delay = 3;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i]  = 1'b0;
            k_s[i]      = '0;
            abort_s[i]  = 1'b0;
            man_done[i] = 1'b0;
        end

        kv = '0;
        kv[N-1] = 1'b1;
        vecs[0] = '{0, N'(5), 4};
        vecs[1] = '{0, N'(0), 1};
        vecs[2] = '{0, N'(1), 1};
        vecs[3] = '{0, kv, 255};
        vecs[4] = '{1, kv, 509};
        vecs[5] = '{1, N'(6), 5};
        vecs[6] = '{0, N'(6), 4};
        vecs[7] = '{0, {N{1'b1}}, 509};
        vecs[8] = '{1, N'(3), 3};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) check_reset(i);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 9; v++) run_mult(vecs[v].sel, vecs[v].k, vecs[v].cnt, -1);

        // abort in WAIT of the 2nd command, op_done 4 cycles after op_start
        pu_delay = 4;
        start_s[0] = 1'b1;
        k_s[0]     = N'(5);
        @(negedge clk);
        start_s[0] = 1'b0;
        n   = 0;
        cyc = 0;
        while (n < 2 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (op_start_s[0]) n++;
        end
        check("abort_reach_2nd_cmd", n, 2);
        @(negedge clk);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        check("abort_busy_c2", busy_s[0], 1);
        @(negedge clk);
        check("abort_busy_c3", busy_s[0], 1);
        @(negedge clk);
        check("abort_busy_c4", busy_s[0], 1);
        check("abort_op_done_c4", op_done_s[0], 1);
        @(negedge clk);
        check("abort_busy_drop", busy_s[0], 0);
        n = 0;
        repeat (10) begin
            if (op_start_s[0] || done_s[0]) n++;
            @(negedge clk);
        end
        check("abort_no_start_no_done", n, 0);
        pu_delay = 3;

        // stray op_done while idle
        man_done[0] = 1'b1;
        @(negedge clk);
        man_done[0] = 1'b0;
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (op_start_s[0] || busy_s[0] || done_s[0]) n++;
        end
        check("stray_done_ignored", n, 0);

        // extra start while busy is ignored
        run_mult(0, N'(5), 4, 5);

        // async reset mid-WAIT
        start_s[0] = 1'b1;
        k_s[0]     = N'(6);
        @(negedge clk);
        start_s[0] = 1'b0;
        cyc = 0;
        while (!op_start_s[0] && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("pre_reset_busy", busy_s[0], 1);
        check("pre_reset_count", op_count_s[0], 1);
        #2 rst_n = 1'b0;
        #1 check_reset(0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_mult(0, N'(3), 3, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Sequencer for Ed25519 variable-base scalar multiplication Q = k·P using left-to-right double-and-add.
- Scans the 255-bit scalar from its most-significant set bit downward.
- Issues LOAD / DBL / ADD / CLEAR commands to the shared extended-coordinate point unit, which holds the accumulator, over a start/done handshake.
- Sits between the signature/keygen top level and the point arithmetic datapath.

Parameters:
N, 255, scalar width in bits; index width IW = $clog2(N).
CONST_TIME, 0, 1 = issue ADD for every scanned bit, with op_discard set when the bit is 0; 0 = ADD only on 1-bits.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request new multiply; accepted only in IDLE
k  in  N  scalar; sampled on the accepted start cycle only
abort  in  1  cancel current multiply
op_start  out  1  one-cycle command pulse to point unit
op_code  out  2  00 LOAD (acc<=P), 01 DBL (acc<=2acc), 10 ADD (acc<=acc+P), 11 CLEAR (acc<=identity)
op_discard  out  1  with ADD: unit computes the sum but does not write the accumulator (CONST_TIME only)
op_done  in  1  one-cycle pulse from point unit: command complete
busy  out  1  high from accepted start until done or abort completion
done  out  1  one-cycle pulse: accumulator holds k·P
bit_idx  out  IW  bit currently being processed
op_count  out  10  commands issued in current multiply; holds after done

Behaviour:
- Reset (async, rst_n low): state IDLE. op_start, op_discard, busy and done = 0. op_code = 00. bit_idx and op_count = 0. Latched scalar cleared.
- States: IDLE, SCAN, ISSUE, WAIT, NEXT, FIN, DRAIN.
- IDLE: on start, latch k into ks, clear op_count, busy<=1, go to SCAN. start in any other state is ignored.
- SCAN (1 cycle): registered priority encode gives m = index of highest set bit of ks.
  - ks == 0: next command is CLEAR.
  - Otherwise: next command is LOAD and bit_idx <= m.
  - Go to ISSUE.
- ISSUE (1 cycle): op_start = 1 with op_code/op_discard valid in that cycle only; op_count += 1; go to WAIT.
  - Cycle timing: start accepted at cycle t, SCAN at t+1, first op_start at t+2.
- WAIT: hold until op_done. op_done arriving in any state other than WAIT is ignored. No timeout.
- NEXT, entered after op_done. Command order per bit i (from m-1 down to 0) is DBL then conditional ADD:
  - After CLEAR: go to FIN.
  - After LOAD, or after the last command for bit i: if bit_idx == 0, go to FIN; else bit_idx -= 1 and issue DBL.
  - After DBL at bit i:
    - ks[i] = 1: issue ADD with op_discard = 0.
    - ks[i] = 0 and CONST_TIME = 1: issue ADD with op_discard = 1.
    - ks[i] = 0 and CONST_TIME = 0: treat bit i as complete.
  - Issuing a command means going to ISSUE the next cycle, so there is exactly one idle cycle between op_done and the next op_start.
- FIN (1 cycle): done = 1 and busy <= 0 in the same cycle; return to IDLE.
  - A start arriving in the FIN cycle is ignored.
- Command totals:
  - Non-CT: 1 + m + (popcount(k) - 1).
  - CT: 1 + 2m.
  - k = 0: 1 (CLEAR only).
  - Maximum 509, which fits in op_count.
- abort:
  - In SCAN or ISSUE: the command in progress is still issued, then the controller goes to DRAIN.
  - In WAIT or NEXT: go to DRAIN. If op_done has already been received, go directly to IDLE instead.
  - DRAIN: wait for op_done of the outstanding command, then IDLE with busy = 0.
  - No done pulse after an abort. abort in IDLE has no effect.
- Asynchronous reset mid-operation: immediate return to the reset state. The point unit is reset by the same rst_n.
- No combinational path from op_done to op_start.

Test Plan:
- k=5, CONST_TIME=0, point unit done 3 cycles after each op_start → op_codes LOAD, DBL, DBL, ADD; bit_idx at each op_start = 2, 1, 0, 0; op_count = 4; first op_start at t+2; done one cycle after the last op_done + 1 cycle, with busy falling in that cycle.
- k=0 → single CLEAR, then done; op_count = 1. k=1 → single LOAD, then done; op_count = 1.
- k=2^254, CONST_TIME=0 → LOAD then 254 DBL, no ADD; op_count = 255. Same k with CONST_TIME=1 → 509 commands; every ADD has op_discard = 1.
- k=6 (110), CONST_TIME=1 → LOAD, DBL, ADD (discard 0), DBL, ADD (discard 1); op_count = 5.
- abort asserted in WAIT during the 2nd command, op_done 4 cycles later → no further op_start, busy drops the cycle after op_done, done never pulses.
- Stray op_done in IDLE, start asserted while busy, and rst_n pulled low mid-WAIT → no reaction to the stray op_done or the extra start; after reset all outputs return to their reset values asynchronously; a following k=3 multiply completes normally (LOAD, DBL, ADD).
